shift_rotate_pipe: RTL and testbench
====================================

# shift_rotate_pipe

- Pipelined, parametrised shift/rotate unit for WIDTH-bit operands.
- Five operations on a valid/ready stream: rotate left, rotate right, logical left, logical right and arithmetic right.
- One log2 stage per pipeline register, so any power-of-two width closes timing.
- Sits between the register-read stage and the writeback/accumulate logic of datapath blocks, replacing ad-hoc combinational rotators.

## Interface
Parameters:
- WIDTH, 8, operand width; power of two, ≥ 2.
- SHW, $clog2(WIDTH), shift-amount width and pipeline depth; derived, not overridden.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- s_valid  in  1  input transaction valid.
- s_ready  out  1  unit can accept input this cycle.
- s_op  in  3  operation code; see Operation.
- s_shamt  in  SHW  shift amount, 0..WIDTH-1.
- s_data  in  WIDTH  operand.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- m_data  out  WIDTH  result.
- m_carry  out  1  last bit moved out (only with SHROT_FLAGS_EN).
- m_zero  out  1  m_data == 0 (only with SHROT_FLAGS_EN).

## Operation
- Opcodes:
  - 3'd0 ROL.
  - 3'd1 ROR.
  - 3'd2 SLL (zero fill).
  - 3'd3 SRL (zero fill).
  - 3'd4 SRA (sign fill from operand MSB).
  - 3'd5..7 reserved: data passes through unchanged, carry 0.
- Right operations reverse the bits, shift left, then reverse again. The fill bit for SRA is captured at acceptance and carried down the pipe.
- Stage k (k = 0..SHW-1) shifts or rotates by 2^k when shamt bit k is 1, otherwise passes through. Each stage registers data, op, remaining shamt bits, fill bit, carry and valid.
- shamt = 0 gives the operand unchanged for every op, with carry 0.
- There is no modulo beyond SHW bits; rotate by WIDTH is not expressible.
- Handshake:
  - Input transfer when s_valid && s_ready.
  - Output transfer when m_valid && m_ready.
  - m_data, m_carry and m_zero are held stable while m_valid && !m_ready.
- Stall is global: s_ready = !m_valid || m_ready. When stalled, every stage holds. Bubbles are not collapsed.
- Ordering is strictly preserved; no transaction is dropped or duplicated.

## Timing
- Reset: every stage valid bit is 0, so m_valid = 0.
  - Output values after reset: m_data = 0, m_carry = 0, m_zero = 0.
  - s_ready is 1 in the first cycle after reset.
- Latency: input accepted at edge e appears on m_* immediately after edge e+SHW-1, provided there is no stall. Example: WIDTH = 8 gives 3 register stages.
- Throughput: one transaction per cycle while m_ready = 1.
- Stall: if m_ready is low while m_valid is high, s_ready drops combinationally in the same cycle. It recovers in the cycle m_ready rises.
- Reset mid-operation: every in-flight transaction is discarded, and m_valid is 0 after the reset edge.
- Input while stalled: an input presented while s_ready = 0 is not consumed. The source must hold it.

## Configuration
- SHROT_FLAGS_EN defined:
  - m_carry and m_zero exist.
  - m_carry = the last bit shifted out for SLL/SRL/SRA, or the last bit wrapped for ROL/ROR. Stage carry updates only on stages whose shamt bit is 1.
  - m_zero is computed from the final-stage data register.
- SHROT_FLAGS_EN not defined:
  - The ports are absent.
  - No carry or zero registers are built.
  - Data behaviour and latency are identical.

## Structure
- Shared package shift_rotate_pkg holds:
  - the op enum (OP_ROL, OP_ROR, OP_SLL, OP_SRL, OP_SRA);
  - the opcode width constant;
  - a function reverse_bits.
- Sub-module shift_stage, parametrised by WIDTH and stage index K:
  - combinational shift/rotate by 2^K, with fill and carry-out;
  - instantiated SHW times by a generate loop, with registers in the top level.

## Test plan
All at WIDTH = 8.
- ROL 8'hB1 by 3 → 8'h8D after 3 edges; ROR 8'hB1 by 3 → 8'h36.
- SRA 8'h90 by 2 → 8'hE4; SRL 8'h90 by 2 → 8'h24; SLL 8'h81 by 1 → 8'h02 with m_carry = 1.
- shamt 0 with each op on 8'h5A → 8'h5A, m_carry = 0; reserved op 3'd6 → passthrough.
- Eight back-to-back inputs with m_ready held low for 5 cycles mid-stream:
  - s_ready falls in the same cycle as the stall;
  - all eight results arrive in order, with none lost or duplicated;
  - m_data is stable throughout the stall.
- Assert rst with 3 transactions in flight → m_valid = 0 after the edge, no stale result appears, s_ready = 1.
- Random op/shamt/data, 10k transactions with random m_ready → scoreboard against the reference-model function.

Source files
------------

// File: rtl/shift_rotate_pkg.sv
// rtl/shift_rotate_pkg.sv - shared op encoding and bit-reverse helper for shift_rotate_pipe
// Optional flag outputs are selected by SHROT_FLAGS_EN in the users of this package.
package shift_rotate_pkg;

  localparam int OP_W      = 3;
  localparam int REV_MAX_W = 256;

  typedef enum logic [OP_W-1:0] {
    OP_ROL = 3'd0,
    OP_ROR = 3'd1,
    OP_SLL = 3'd2,
    OP_SRL = 3'd3,
    OP_SRA = 3'd4
  } op_e;

  // Reverses the low w bits of v; callers narrow the result back to their width.
  function automatic logic [REV_MAX_W-1:0] reverse_bits(input logic [REV_MAX_W-1:0] v,
                                                        input int unsigned w);
    logic [REV_MAX_W-1:0] r;
    r = {<<{v}};
    return r >> (REV_MAX_W - w);
  endfunction

  function automatic logic is_right_op(input op_e op);
    return (op == OP_ROR) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - combinational left shift/rotate by 2^K with fill
// Carry in/out ports exist only when SHROT_FLAGS_EN is defined.
module shift_stage
  import shift_rotate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int K     = 0
) (
  input  logic [WIDTH-1:0] data_i,
  input  op_e              op_i,
  input  logic             fill_i,
  input  logic             shift_en_i,
`ifdef SHROT_FLAGS_EN
  input  logic             carry_i,
  output logic             carry_o,
`endif
  output logic [WIDTH-1:0] data_o
);

  localparam int S = 1 << K;
  localparam logic [WIDTH-1:0] LOW_MASK = ~({WIDTH{1'b1}} << S);

  logic [WIDTH-1:0] rotated;
  logic [WIDTH-1:0] shifted;

  assign rotated = (data_i << S) | (data_i >> (WIDTH - S));
  assign shifted = (data_i << S) | (fill_i ? LOW_MASK : '0);

  // Right ops arrive bit-reversed, so every op is a left move here.
  always_comb begin
    data_o = data_i;
`ifdef SHROT_FLAGS_EN
    carry_o = carry_i;
`endif
    if (shift_en_i) begin
      case (op_i)
        OP_ROL, OP_ROR: begin
          data_o = rotated;
`ifdef SHROT_FLAGS_EN
          carry_o = data_i[WIDTH-S];
`endif
        end
        OP_SLL, OP_SRL, OP_SRA: begin
          data_o = shifted;
`ifdef SHROT_FLAGS_EN
          carry_o = data_i[WIDTH-S];
`endif
        end
        default: begin
          data_o = data_i;
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_rotate_pipe.sv
// rtl/shift_rotate_pipe.sv - pipelined WIDTH-bit shift/rotate unit, one log2 stage per register
// Defining SHROT_FLAGS_EN adds the m_carry and m_zero outputs.
module shift_rotate_pipe
  import shift_rotate_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [OP_W-1:0]  s_op,
  input  logic [SHW-1:0]   s_shamt,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
`ifdef SHROT_FLAGS_EN
  output logic             m_carry,
  output logic             m_zero,
`endif
  output logic [WIDTH-1:0] m_data
);

  logic             advance;
  op_e              in_op;
  logic [WIDTH-1:0] in_data;
  logic             in_fill;

  // Stall is global: the whole pipe moves or the whole pipe holds.
  assign advance = !m_valid || m_ready;
  assign s_ready = advance;

  assign in_op   = op_e'(s_op);
  assign in_data = is_right_op(in_op) ? WIDTH'(reverse_bits(REV_MAX_W'(s_data), WIDTH)) : s_data;
  assign in_fill = (in_op == OP_SRA) && s_data[WIDTH-1];

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int RW = SHW - k;

    logic             valid_in;
    logic [WIDTH-1:0] data_in;
    op_e              op_in;
    logic [RW-1:0]    shamt_in;
    logic             fill_in;
    logic [WIDTH-1:0] data_d;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    op_e              op_q;
`ifdef SHROT_FLAGS_EN
    logic             carry_in;
    logic             carry_d;
    logic             carry_q;
`endif

    if (k == 0) begin : g_head
      assign valid_in = s_valid;
      assign data_in  = in_data;
      assign op_in    = in_op;
      assign shamt_in = s_shamt;
      assign fill_in  = in_fill;
`ifdef SHROT_FLAGS_EN
      assign carry_in = 1'b0;
`endif
    end else begin : g_body
      assign valid_in = g_stage[k-1].valid_q;
      assign data_in  = g_stage[k-1].data_q;
      assign op_in    = g_stage[k-1].op_q;
      assign shamt_in = g_stage[k-1].g_fwd.shamt_q;
      assign fill_in  = g_stage[k-1].g_fwd.fill_q;
`ifdef SHROT_FLAGS_EN
      assign carry_in = g_stage[k-1].carry_q;
`endif
    end

    shift_stage #(
      .WIDTH (WIDTH),
      .K     (k)
    ) u_stage (
      .data_i     (data_in),
      .op_i       (op_in),
      .fill_i     (fill_in),
      .shift_en_i (shamt_in[0]),
`ifdef SHROT_FLAGS_EN
      .carry_i    (carry_in),
      .carry_o    (carry_d),
`endif
      .data_o     (data_d)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        op_q    <= OP_ROL;
`ifdef SHROT_FLAGS_EN
        carry_q <= 1'b0;
`endif
      end else if (advance) begin
        valid_q <= valid_in;
        data_q  <= data_d;
        op_q    <= op_in;
`ifdef SHROT_FLAGS_EN
        carry_q <= carry_d;
`endif
      end
    end

    // Only the not-yet-consumed shift bits and the fill travel onward.
    if (k < SHW - 1) begin : g_fwd
      logic [RW-2:0] shamt_q;
      logic          fill_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          shamt_q <= '0;
          fill_q  <= 1'b0;
        end else if (advance) begin
          shamt_q <= shamt_in[RW-1:1];
          fill_q  <= fill_in;
        end
      end
    end
  end

  logic [WIDTH-1:0] last_data;
  op_e              last_op;

  assign last_data = g_stage[SHW-1].data_q;
  assign last_op   = g_stage[SHW-1].op_q;
  assign m_valid   = g_stage[SHW-1].valid_q;
  assign m_data    = is_right_op(last_op) ? WIDTH'(reverse_bits(REV_MAX_W'(last_data), WIDTH))
                                          : last_data;

`ifdef SHROT_FLAGS_EN
  assign m_carry = g_stage[SHW-1].carry_q;
  assign m_zero  = m_valid && (last_data == '0);
`endif

endmodule

// File: tb/tb_shift_rotate_pipe.sv
// tb/tb_shift_rotate_pipe.sv - scoreboard bench for shift_rotate_pipe at WIDTH = 8
// Flag outputs are checked only when SHROT_FLAGS_EN is defined.
module tb_shift_rotate_pipe;

  localparam int W   = 8;
  localparam int SHW = 3;
  localparam int N_RANDOM = 10000;

  logic           clk = 1'b0;
  logic           rst;
  logic           s_valid;
  logic           s_ready;
  logic [2:0]     s_op;
  logic [SHW-1:0] s_shamt;
  logic [W-1:0]   s_data;
  logic           m_valid;
  logic           m_ready;
  logic [W-1:0]   m_data;
`ifdef SHROT_FLAGS_EN
  logic           m_carry;
  logic           m_zero;
`endif

  shift_rotate_pipe #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_op    (s_op),
    .s_shamt (s_shamt),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
`ifdef SHROT_FLAGS_EN
    .m_carry (m_carry),
    .m_zero  (m_zero),
`endif
    .m_data  (m_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         c;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_push = 0;
  int   n_pop  = 0;
  bit   accepted = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on the operand, carry = last bit to leave the word.
  function automatic exp_t model(input logic [2:0] op, input int n, input logic [W-1:0] d);
    exp_t e;
    e.d = d;
    e.c = 1'b0;
    if (n == 0) return e;
    case (op)
      3'd0: begin e.d = (d << n) | (d >> (W - n)); e.c = d[W-n]; end
      3'd1: begin e.d = (d >> n) | (d << (W - n)); e.c = d[n-1]; end
      3'd2: begin e.d = d << n;                    e.c = d[W-n]; end
      3'd3: begin e.d = d >> n;                    e.c = d[n-1]; end
      3'd4: begin e.d = W'($signed(d) >>> n);      e.c = d[n-1]; end
      default: ;
    endcase
    return e;
  endfunction

  // Monitor: every presented result is compared with the queue head until it is taken.
  always @(negedge clk) begin
    accepted = 1'b0;
    if (rst) begin
      q.delete();
    end else begin
      check("s_ready_rule", s_ready, !m_valid || m_ready);
      if (m_valid) begin
        if (q.size() == 0) begin
          check("unexpected_output", m_valid, 1'b0);
        end else begin
          check("m_data", m_data, q[0].d);
`ifdef SHROT_FLAGS_EN
          check("m_carry", m_carry, q[0].c);
          check("m_zero", m_zero, q[0].d == '0);
`endif
          if (m_ready) begin
            void'(q.pop_front());
            n_pop++;
          end
        end
      end
      if (s_valid && s_ready) begin
        q.push_back(model(s_op, int'(s_shamt), s_data));
        n_push++;
        accepted = 1'b1;
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [2:0] sh, input logic [W-1:0] d);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_op    = op;
    s_shamt = sh;
    s_data  = d;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!accepted && t < 200);
    check("send_accept", accepted, 1'b1);
  endtask

  task automatic directed(input string name, input logic [2:0] op, input logic [2:0] sh,
                          input logic [W-1:0] d, input logic [W-1:0] exp_d, input logic exp_c);
    int edges;
    m_ready = 1'b1;
    send(op, sh, d);
    s_valid = 1'b0;
    edges = 1;
    while (!m_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({name, "_latency"}, edges, SHW);
    check({name, "_data"}, m_data, exp_d);
`ifdef SHROT_FLAGS_EN
    check({name, "_carry"}, m_carry, exp_c);
`else
    if (exp_c === 1'bx) $display("unreachable");
`endif
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [2:0]   sh;
    logic [W-1:0] d;
    logic [W-1:0] exp_d;
    logic         exp_c;
  } vec_t;

  initial begin
    vec_t vecs[$];
    int   t;
    int   pop0;
    int   cyc;

    rst     = 1'b1;
    s_valid = 1'b0;
    s_op    = '0;
    s_shamt = '0;
    s_data  = '0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset_m_valid", m_valid, 1'b0);
    check("reset_m_data", m_data, 8'h00);
    check("reset_s_ready", s_ready, 1'b1);
`ifdef SHROT_FLAGS_EN
    check("reset_m_carry", m_carry, 1'b0);
    check("reset_m_zero", m_zero, 1'b0);
`endif

    vecs.push_back('{"rol_b1_3", 3'd0, 3'd3, 8'hB1, 8'h8D, 1'b1});
    vecs.push_back('{"ror_b1_3", 3'd1, 3'd3, 8'hB1, 8'h36, 1'b0});
    vecs.push_back('{"sra_90_2", 3'd4, 3'd2, 8'h90, 8'hE4, 1'b0});
    vecs.push_back('{"srl_90_2", 3'd3, 3'd2, 8'h90, 8'h24, 1'b0});
    vecs.push_back('{"sll_81_1", 3'd2, 3'd1, 8'h81, 8'h02, 1'b1});
    vecs.push_back('{"rol_sh0",  3'd0, 3'd0, 8'h5A, 8'h5A, 1'b0});
    vecs.push_back('{"ror_sh0",  3'd1, 3'd0, 8'h5A, 8'h5A, 1'b0});
    vecs.push_back('{"sll_sh0",  3'd2, 3'd0, 8'h5A, 8'h5A, 1'b0});
    vecs.push_back('{"srl_sh0",  3'd3, 3'd0, 8'h5A, 8'h5A, 1'b0});
    vecs.push_back('{"sra_sh0",  3'd4, 3'd0, 8'h5A, 8'h5A, 1'b0});
    vecs.push_back('{"rsvd6",    3'd6, 3'd3, 8'h5A, 8'h5A, 1'b0});
    vecs.push_back('{"sll_ff_7", 3'd2, 3'd7, 8'hFF, 8'h80, 1'b1});
    foreach (vecs[i])
      directed(vecs[i].name, vecs[i].op, vecs[i].sh, vecs[i].d, vecs[i].exp_d, vecs[i].exp_c);

    // Eight back-to-back inputs with a five-cycle output stall in the middle.
    pop0 = n_pop;
    m_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(3'($urandom_range(0, 4)), 3'($urandom), 8'($urandom));
        s_valid = 1'b0;
      end
      begin
        t = 0;
        while (!m_valid && t < 50) begin
          @(posedge clk);
          #1;
          t++;
        end
        m_ready = 1'b0;
        #1;
        check("stall_s_ready_drop", s_ready, 1'b0);
        repeat (5) begin
          @(posedge clk);
          #1;
        end
        m_ready = 1'b1;
        #1;
        check("stall_s_ready_recover", s_ready, 1'b1);
      end
    join
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("stall_all_delivered", n_pop - pop0, 8);

    // Reset with transactions in flight.
    send(3'd0, 3'd1, 8'h11);
    send(3'd2, 3'd2, 8'h22);
    send(3'd3, 3'd3, 8'h33);
    s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midreset_m_valid", m_valid, 1'b0);
    check("midreset_s_ready", s_ready, 1'b1);
    check("midreset_m_data", m_data, 8'h00);
    repeat (6) begin
      @(posedge clk);
      #1;
      check("post_reset_idle", m_valid, 1'b0);
    end

    // Random traffic with random backpressure.
    pop0 = n_pop;
    t    = n_push;
    cyc  = 0;
    while ((n_push - t) < N_RANDOM && cyc < 80000) begin
      if (!s_valid || accepted) begin
        if ((n_push - t) < N_RANDOM && $urandom_range(0, 4) != 0) begin
          s_valid = 1'b1;
          s_op    = 3'($urandom);
          s_shamt = 3'($urandom);
          s_data  = 8'($urandom);
        end else begin
          s_valid = 1'b0;
        end
      end
      m_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
      cyc++;
    end
    if (accepted) s_valid = 1'b0;
    while (s_valid && cyc < 80100) begin
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      if (accepted) s_valid = 1'b0;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    check("random_issued", n_push - t, N_RANDOM);
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("random_drained", q.size(), 0);
    check("random_delivered", n_pop - pop0, N_RANDOM);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
